// File: rtl/ram512x32_rr_arb_if.sv
// Requester A/B handshake and block-RAM pin bundle for ram512x32_rr_arb.
// The slave modport is the arbiter; the master modport is the clients plus the RAM.
interface ram512x32_rr_arb_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic              ReqA;
    logic              WeA;
    logic [BE_W-1:0]   BeA;
    logic [ADDR_W-1:0] AddrA;
    logic [DATA_W-1:0] WdA;
    logic              GntA;
    logic              RvalidA;
    logic [DATA_W-1:0] RdA;

    logic              ReqB;
    logic              WeB;
    logic [BE_W-1:0]   BeB;
    logic [ADDR_W-1:0] AddrB;
    logic [DATA_W-1:0] WdB;
    logic              GntB;
    logic              RvalidB;
    logic [DATA_W-1:0] RdB;

    logic [ADDR_W-1:0] RamWA;
    logic [ADDR_W-1:0] RamRA;
    logic [DATA_W-1:0] RamWD;
    logic [BE_W-1:0]   RamWEN;
    logic              RamWClkEn;
    logic              RamRClkEn;
    logic [DATA_W-1:0] RamRD;

    logic              InitDone;
    logic              Busy;

    modport slave (
        input  ReqA, WeA, BeA, AddrA, WdA,
        output GntA, RvalidA, RdA,
        input  ReqB, WeB, BeB, AddrB, WdB,
        output GntB, RvalidB, RdB,
        output RamWA, RamRA, RamWD, RamWEN, RamWClkEn, RamRClkEn,
        input  RamRD,
        output InitDone, Busy
    );

    modport master (
        output ReqA, WeA, BeA, AddrA, WdA,
        input  GntA, RvalidA, RdA,
        output ReqB, WeB, BeB, AddrB, WdB,
        input  GntB, RvalidB, RdB,
        input  RamWA, RamRA, RamWD, RamWEN, RamWClkEn, RamRClkEn,
        output RamRD,
        input  InitDone, Busy
    );
endinterface

// File: rtl/ram512x32_rr_arb.sv
// Round-robin sharing of one 512x32 byte-writable block RAM between requesters A and B.
// Define RAM512X32_ARB_CLEAR_EN to sweep CLEAR_VAL through every word after reset.
module ram512x32_rr_arb #(
    parameter int                ADDR_W    = 9,
    parameter int                DATA_W    = 32,
    parameter int                BE_W      = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = 32'h0000_0000
) (
    input  logic              Clk,
    input  logic              Rst,
    ram512x32_rr_arb_if.slave bus
);
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e            state_r;
    state_e            state_s;
    logic              ptr_b_r;
    logic              rvalid_a_r;
    logic              rvalid_b_r;
    logic [DATA_W-1:0] rd_a_r;
    logic [DATA_W-1:0] rd_b_r;
    logic [ADDR_W-1:0] wa_hold_r;
    logic [ADDR_W-1:0] ra_hold_r;
    logic [DATA_W-1:0] wd_hold_r;
    logic [ADDR_W-1:0] clr_addr_s;

    logic              gnt_a_s;
    logic              gnt_b_s;
    logic              gnt_any_s;
    logic              clearing_s;
    logic              op_we_s;
    logic [BE_W-1:0]   op_be_s;
    logic [ADDR_W-1:0] op_addr_s;
    logic [DATA_W-1:0] op_wd_s;
    logic [ADDR_W-1:0] ram_wa_s;
    logic [ADDR_W-1:0] ram_ra_s;
    logic [DATA_W-1:0] ram_wd_s;
    logic [BE_W-1:0]   ram_wen_s;
    logic              ram_wclken_s;
    logic              ram_rclken_s;

`ifdef RAM512X32_ARB_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
    logic [ADDR_W-1:0] clr_addr_r;

    // Clear sweep address, restarting at zero on every reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            clr_addr_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            clr_addr_r <= clr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign clr_addr_s = clr_addr_r;
`else
    localparam state_e RESET_STATE = ST_RUN;
    assign clr_addr_s = {ADDR_W{1'b0}};
`endif

    assign clearing_s = ~Rst & (state_r == ST_CLEAR);
    assign gnt_any_s  = gnt_a_s | gnt_b_s;

    // Round-robin grant; on contention the side not granted last wins.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (Rst || (state_r != ST_RUN)) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else if (bus.ReqA && bus.ReqB) begin
            gnt_a_s = ~ptr_b_r;
            gnt_b_s = ptr_b_r;
        end else begin
            gnt_a_s = bus.ReqA;
            gnt_b_s = bus.ReqB;
        end
    end

    // Fields of the granted side.
    always_comb begin
        op_we_s   = bus.WeA;
        op_be_s   = bus.BeA;
        op_addr_s = bus.AddrA;
        op_wd_s   = bus.WdA;
        if (gnt_b_s) begin
            op_we_s   = bus.WeB;
            op_be_s   = bus.BeB;
            op_addr_s = bus.AddrB;
            op_wd_s   = bus.WdB;
        end else begin
            op_we_s   = bus.WeA;
            op_be_s   = bus.BeA;
            op_addr_s = bus.AddrA;
            op_wd_s   = bus.WdA;
        end
    end

    // RAM pins: the clear sweep or the granted op; otherwise enables drop and buses hold.
    always_comb begin
        ram_wa_s     = wa_hold_r;
        ram_ra_s     = ra_hold_r;
        ram_wd_s     = wd_hold_r;
        ram_wen_s    = {BE_W{1'b0}};
        ram_wclken_s = 1'b0;
        ram_rclken_s = 1'b0;
        if (clearing_s) begin
            ram_wa_s     = clr_addr_s;
            ram_wd_s     = CLEAR_VAL;
            ram_wen_s    = {BE_W{1'b1}};
            ram_wclken_s = 1'b1;
        end else if (gnt_any_s && op_we_s) begin
            ram_wa_s     = op_addr_s;
            ram_wd_s     = op_wd_s;
            ram_wen_s    = op_be_s;
            ram_wclken_s = 1'b1;
        end else if (gnt_any_s) begin
            ram_ra_s     = op_addr_s;
            ram_rclken_s = 1'b1;
        end else begin
            ram_wen_s    = {BE_W{1'b0}};
        end
    end

    // Next state: the sweep ends once the last address has been written.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (&clr_addr_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_RUN;
        endcase
    end

    // State, priority pointer, read-return tracking and held RAM buses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= RESET_STATE;
            ptr_b_r    <= 1'b0;
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
            rd_a_r     <= {DATA_W{1'b0}};
            rd_b_r     <= {DATA_W{1'b0}};
            wa_hold_r  <= {ADDR_W{1'b0}};
            ra_hold_r  <= {ADDR_W{1'b0}};
            wd_hold_r  <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            if (gnt_a_s) begin
                ptr_b_r <= 1'b1;
            end else if (gnt_b_s) begin
                ptr_b_r <= 1'b0;
            end
            rvalid_a_r <= gnt_a_s & ~op_we_s;
            rvalid_b_r <= gnt_b_s & ~op_we_s;
            if (rvalid_a_r) begin
                rd_a_r <= bus.RamRD;
            end
            if (rvalid_b_r) begin
                rd_b_r <= bus.RamRD;
            end
            wa_hold_r  <= ram_wa_s;
            ra_hold_r  <= ram_ra_s;
            wd_hold_r  <= ram_wd_s;
        end
    end

    // Read data is live from the RAM in the return cycle and held afterwards.
    assign bus.GntA      = gnt_a_s;
    assign bus.GntB      = gnt_b_s;
    assign bus.RvalidA   = rvalid_a_r & ~Rst;
    assign bus.RvalidB   = rvalid_b_r & ~Rst;
    assign bus.RdA       = Rst ? {DATA_W{1'b0}} : (rvalid_a_r ? bus.RamRD : rd_a_r);
    assign bus.RdB       = Rst ? {DATA_W{1'b0}} : (rvalid_b_r ? bus.RamRD : rd_b_r);
    assign bus.RamWA     = ram_wa_s;
    assign bus.RamRA     = ram_ra_s;
    assign bus.RamWD     = ram_wd_s;
    assign bus.RamWEN    = ram_wen_s;
    assign bus.RamWClkEn = ram_wclken_s;
    assign bus.RamRClkEn = ram_rclken_s;
    assign bus.InitDone  = ~Rst & (state_r == ST_RUN);
    assign bus.Busy      = ~Rst & (gnt_any_s | rvalid_a_r | rvalid_b_r | clearing_s);
endmodule

// File: tb/tb_ram512x32_rr_arb.sv
// Bench for ram512x32_rr_arb: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbiter and the memory contents.
module tb_ram512x32_rr_arb;
`ifdef RAM512X32_ARB_CLEAR_EN
    localparam bit CLEAR_ON = 1'b1;
`else
    localparam bit CLEAR_ON = 1'b0;
`endif
    localparam logic [31:0] CLEAR_WORD = 32'h0000_0000;

    logic Clk = 1'b0;
    logic Rst;
    int   tests = 0;
    int   fails = 0;

    always #5 Clk = ~Clk;

    ram512x32_rr_arb_if #(.ADDR_W(9), .DATA_W(32), .BE_W(4)) bus ();

    ram512x32_rr_arb #(.ADDR_W(9), .DATA_W(32), .BE_W(4), .CLEAR_VAL(CLEAR_WORD)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Block RAM behaviour: byte writes, registered read.
    logic [31:0] ram_q [512];
    always @(posedge Clk) begin
        if (bus.RamWClkEn) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.RamWEN[i]) ram_q[bus.RamWA][8*i +: 8] <= bus.RamWD[8*i +: 8];
            end
        end
        if (bus.RamRClkEn) bus.RamRD <= ram_q[bus.RamRA];
    end

    // Reference model: expected memory image, last-granted side, pending returns.
    logic [31:0] m_mem [512];
    bit          m_pref_b;
    bit          m_pend_a, m_pend_b;
    logic [31:0] m_pdata_a, m_pdata_b, m_rd_a, m_rd_b;
    bit          m_clearing;
    int          m_clr_idx;

    always @(negedge Clk) begin
        bit          ga, gb, we;
        logic [3:0]  be;
        logic [8:0]  ad;
        logic [31:0] wd;
        if (Rst) begin
            chk("rst_gnt_a",    32'(bus.GntA), 32'd0);
            chk("rst_gnt_b",    32'(bus.GntB), 32'd0);
            chk("rst_rvalid",   32'({bus.RvalidA, bus.RvalidB}), 32'd0);
            chk("rst_rd_a",     bus.RdA, 32'd0);
            chk("rst_rd_b",     bus.RdB, 32'd0);
            chk("rst_initdone", 32'(bus.InitDone), 32'd0);
            chk("rst_busy",     32'(bus.Busy), 32'd0);
            chk("rst_ram_en",   32'({bus.RamWEN, bus.RamWClkEn, bus.RamRClkEn}), 32'd0);
            m_pref_b = 1'b0; m_pend_a = 1'b0; m_pend_b = 1'b0;
            m_rd_a = 32'd0; m_rd_b = 32'd0;
            m_clearing = CLEAR_ON; m_clr_idx = 0;
        end else begin
            ga = 1'b0; gb = 1'b0;
            if (!m_clearing) begin
                if (bus.ReqA && bus.ReqB) begin ga = !m_pref_b; gb = m_pref_b; end
                else begin ga = bus.ReqA; gb = bus.ReqB; end
            end
            if (gb) begin we = bus.WeB; be = bus.BeB; ad = bus.AddrB; wd = bus.WdB; end
            else    begin we = bus.WeA; be = bus.BeA; ad = bus.AddrA; wd = bus.WdA; end
            chk("gnt_a",    32'(bus.GntA), 32'(ga));
            chk("gnt_b",    32'(bus.GntB), 32'(gb));
            chk("initdone", 32'(bus.InitDone), 32'(!m_clearing));
            chk("rvalid_a", 32'(bus.RvalidA), 32'(m_pend_a));
            chk("rvalid_b", 32'(bus.RvalidB), 32'(m_pend_b));
            chk("rd_a",     bus.RdA, m_pend_a ? m_pdata_a : m_rd_a);
            chk("rd_b",     bus.RdB, m_pend_b ? m_pdata_b : m_rd_b);
            chk("busy",     32'(bus.Busy), 32'(ga | gb | m_pend_a | m_pend_b | m_clearing));
            if (m_clearing) begin
                chk("clr_wa",  32'(bus.RamWA), 32'(m_clr_idx));
                chk("clr_wd",  bus.RamWD, CLEAR_WORD);
                chk("clr_en",  32'({bus.RamWEN, bus.RamWClkEn, bus.RamRClkEn}), 32'b11110);
            end else if ((ga || gb) && we) begin
                chk("wr_wa",   32'(bus.RamWA), 32'(ad));
                chk("wr_wd",   bus.RamWD, wd);
                chk("wr_en",   32'({bus.RamWEN, bus.RamWClkEn, bus.RamRClkEn}), 32'({be, 2'b10}));
            end else if (ga || gb) begin
                chk("rd_ra",   32'(bus.RamRA), 32'(ad));
                chk("rd_en",   32'({bus.RamWEN, bus.RamWClkEn, bus.RamRClkEn}), 32'b00001);
            end else begin
                chk("idle_en", 32'({bus.RamWEN, bus.RamWClkEn, bus.RamRClkEn}), 32'd0);
            end
            if (m_pend_a) m_rd_a = m_pdata_a;
            if (m_pend_b) m_rd_b = m_pdata_b;
            m_pend_a = ga && !we;
            m_pend_b = gb && !we;
            if ((ga || gb) && !we) begin m_pdata_a = m_mem[ad]; m_pdata_b = m_mem[ad]; end
            if ((ga || gb) && we) begin
                for (int i = 0; i < 4; i++) if (be[i]) m_mem[ad][8*i +: 8] = wd[8*i +: 8];
            end
            if (ga) m_pref_b = 1'b1;
            else if (gb) m_pref_b = 1'b0;
            if (m_clearing) begin
                m_mem[m_clr_idx] = CLEAR_WORD;
                if (m_clr_idx == 511) m_clearing = 1'b0;
                else m_clr_idx++;
            end
        end
    end

    // Tasks below are entered and left 1 time unit after a rising edge.
    task automatic issue(input bit sb, input bit we, input logic [3:0] be,
                         input logic [8:0] addr, input logic [31:0] wd);
        int n = 0;
        if (sb) begin bus.ReqB = 1'b1; bus.WeB = we; bus.BeB = be; bus.AddrB = addr; bus.WdB = wd; end
        else    begin bus.ReqA = 1'b1; bus.WeA = we; bus.BeA = be; bus.AddrA = addr; bus.WdA = wd; end
        #2;
        while (!(sb ? bus.GntB : bus.GntA) && n < 2000) begin @(posedge Clk); #3; n++; end
        if (n >= 2000) chk("grant_timeout", 32'(n), 32'd0);
        @(posedge Clk); #1;
        if (sb) bus.ReqB = 1'b0; else bus.ReqA = 1'b0;
    endtask

    task automatic expect_rd(input bit sb, input logic [31:0] exp, input string name);
        #2;
        chk({name, "_valid"}, 32'(sb ? bus.RvalidB : bus.RvalidA), 32'd1);
        chk(name, sb ? bus.RdB : bus.RdA, exp);
        @(posedge Clk); #1;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!bus.InitDone && n < 1000) begin @(posedge Clk); #1; n++; end
        if (n >= 1000) chk("init_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        bus.ReqA = 1'b0; bus.ReqB = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        wait_init();
    endtask

    initial begin
        int          n;
        logic [5:0]  pat_a, pat_b;
        bit          ga_seen, gb_seen;
        for (int i = 0; i < 512; i++) begin
            ram_q[i] = $urandom | 32'h0000_0100;
            m_mem[i] = ram_q[i];
        end
        bus.RamRD = 32'd0;
        Rst = 1'b1;
        bus.ReqA = 1'b0; bus.WeA = 1'b0; bus.BeA = 4'h0; bus.AddrA = 9'h0; bus.WdA = 32'h0;
        bus.ReqB = 1'b0; bus.WeB = 1'b0; bus.BeB = 4'h0; bus.AddrB = 9'h0; bus.WdB = 32'h0;
        repeat (3) @(posedge Clk);
        #3;
        chk("d_rst_initdone", 32'(bus.InitDone), 32'd0);
        chk("d_rst_busy",     32'(bus.Busy), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        bus.ReqA = 1'b1; bus.WeA = 1'b0; bus.AddrA = 9'h0AB;
        n = 0;
        #2;
        while (!bus.InitDone && n < 600) begin n++; @(posedge Clk); #3; end
        chk("d_init_wait_cycles", 32'(n), CLEAR_ON ? 32'd512 : 32'd0);
        chk("d_first_gnt", 32'(bus.GntA), 32'd1);
        @(posedge Clk); #1;
        bus.ReqA = 1'b0;
        if (CLEAR_ON) expect_rd(1'b0, 32'h0000_0000, "d_clear_rd_0ab");
        else          expect_rd(1'b0, m_mem[9'h0AB], "d_rd_0ab");

        issue(1'b0, 1'b1, 4'hF, 9'h005, 32'hDEAD_BEEF);
        issue(1'b0, 1'b0, 4'h0, 9'h005, 32'h0);
        expect_rd(1'b0, 32'hDEAD_BEEF, "d_rd_a_005");

        issue(1'b1, 1'b1, 4'hF,    9'h010, 32'h1122_3344);
        issue(1'b1, 1'b1, 4'b0101, 9'h010, 32'hAABB_CCDD);
        issue(1'b1, 1'b0, 4'h0,    9'h010, 32'h0);
        expect_rd(1'b1, 32'h11BB_33DD, "d_rd_b_bytes");

        issue(1'b0, 1'b1, 4'h0, 9'h010, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 4'h0, 9'h010, 32'h0);
        expect_rd(1'b0, 32'h11BB_33DD, "d_rd_be0");

        do_reset();
        pat_a = 6'd0; pat_b = 6'd0;
        bus.ReqA = 1'b1; bus.WeA = 1'b0; bus.AddrA = 9'h005;
        bus.ReqB = 1'b1; bus.WeB = 1'b0; bus.AddrB = 9'h010;
        for (int i = 0; i < 6; i++) begin
            #2;
            pat_a[i] = bus.GntA; pat_b[i] = bus.GntB;
            @(posedge Clk); #1;
        end
        bus.ReqA = 1'b0; bus.ReqB = 1'b0;
        chk("d_alt_a", 32'(pat_a), 32'b010101);
        chk("d_alt_b", 32'(pat_b), 32'b101010);
        @(posedge Clk); #1;

        issue(1'b0, 1'b1, 4'hF, 9'h1FF, 32'h0000_0001);
        issue(1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0);
        expect_rd(1'b1, 32'h0000_0001, "d_raw_1ff");

        issue(1'b0, 1'b1, 4'hF, 9'h010, 32'h0000_0000);
        issue(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
        Rst = 1'b1;
        #2;
        chk("d_drop_rvalid_b", 32'(bus.RvalidB), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        wait_init();
        bus.ReqA = 1'b1; bus.WeA = 1'b0; bus.AddrA = 9'h1FF;
        bus.ReqB = 1'b1; bus.WeB = 1'b0; bus.AddrB = 9'h1FF;
        #2;
        chk("d_post_rst_gnt_a", 32'(bus.GntA), 32'd1);
        chk("d_post_rst_gnt_b", 32'(bus.GntB), 32'd0);
        @(posedge Clk); #1;
        bus.ReqA = 1'b0;
        #2;
        chk("d_post_rst_gnt_b2", 32'(bus.GntB), 32'd1);
        @(posedge Clk); #1;
        bus.ReqB = 1'b0;

        ga_seen = 1'b0; gb_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            Rst = ($urandom_range(0, 299) == 0);
            if (!bus.ReqA || ga_seen) begin
                bus.ReqA = ($urandom_range(0, 3) != 0); bus.WeA = $urandom_range(0, 1);
                bus.BeA = 4'($urandom); bus.AddrA = 9'($urandom_range(0, 15)); bus.WdA = $urandom;
            end
            if (!bus.ReqB || gb_seen) begin
                bus.ReqB = ($urandom_range(0, 3) != 0); bus.WeB = $urandom_range(0, 1);
                bus.BeB = 4'($urandom); bus.AddrB = 9'($urandom_range(0, 15)); bus.WdB = $urandom;
            end
            #2;
            ga_seen = bus.GntA; gb_seen = bus.GntB;
            @(posedge Clk); #1;
        end
        Rst = 1'b0; bus.ReqA = 1'b0; bus.ReqB = 1'b0;
        repeat (3) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end
endmodule
